// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, opcode/funct constants and the issue entry payload.
// Consumed by the issue stage and by the ALU itself.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_RD_W   = 5;
  localparam int unsigned ALU_CTRL_W = 3;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_ctrl_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SRA = 3'b101;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    alu_ctrl_e             ctrl;
    logic [ALU_DATA_W-1:0] data1;
    logic [ALU_DATA_W-1:0] data2;
    logic [ALU_RD_W-1:0]   rd;
  } issue_entry_t;

  // Sign-extend a 12-bit I-type immediate to the operand width.
  function automatic logic [ALU_DATA_W-1:0] sext12(input logic [11:0] imm);
    return {{(ALU_DATA_W - 12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream (register read) and downstream (ALU) handshake bundle of the issue stage.
// slave = the issue stage's view, master = the surrounding pipeline's view.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_W   = 5
);

  logic              valid_i;
  logic              ready_o;
  logic [31:0]       inst_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;

  logic              valid_o;
  logic              ready_i;
  logic [2:0]        ALUCtrl_o;
  logic [DATA_W-1:0] data1_o;
  logic [DATA_W-1:0] data2_o;
  logic [RD_W-1:0]   rd_o;

  modport slave (
    input  valid_i, inst_i, rs1_data_i, rs2_data_i, ready_i,
    output ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, rd_o
  );

  modport master (
    output valid_i, inst_i, rs1_data_i, rs2_data_i, ready_i,
    input  ready_o, valid_o, ALUCtrl_o, data1_o, data2_o, rd_o
  );

endinterface

// File: rtl/alu_issue_dec.sv
// Combinational RV32 decoder: instruction + register data -> ALU issue entry and illegal flag.
module alu_issue_dec
  import alu_pkg::*;
(
  input  logic [31:0]           inst,
  input  logic [ALU_DATA_W-1:0] rs1_data,
  input  logic [ALU_DATA_W-1:0] rs2_data,
  output issue_entry_t          entry_c,
  output logic                  illegal_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       unused_rs_idx;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register indices were consumed by the register file read upstream.
  assign unused_rs_idx = ^inst[19:15];

  // Decode table lookup and operand selection.
  always_comb begin
    entry_c       = '0;
    legal         = 1'b0;
    entry_c.data1 = rs1_data;
    entry_c.data2 = rs2_data;
    entry_c.rd    = inst[11:7];
    case (opcode)
      OP_RTYPE: begin
        case ({funct7, funct3})
          {F7_BASE,   F3_AND}: begin entry_c.ctrl = ALU_AND; legal = 1'b1; end
          {F7_BASE,   F3_XOR}: begin entry_c.ctrl = ALU_XOR; legal = 1'b1; end
          {F7_BASE,   F3_SLL}: begin entry_c.ctrl = ALU_SLL; legal = 1'b1; end
          {F7_BASE,   F3_ADD}: begin entry_c.ctrl = ALU_ADD; legal = 1'b1; end
          {F7_ALT,    F3_ADD}: begin entry_c.ctrl = ALU_SUB; legal = 1'b1; end
          {F7_MULDIV, F3_ADD}: begin entry_c.ctrl = ALU_MUL; legal = 1'b1; end
          default:             legal = 1'b0;
        endcase
      end
      OP_ITYPE: begin
        if (funct3 == F3_ADD) begin
          entry_c.ctrl  = ALU_ADDI;
          entry_c.data2 = sext12(inst[31:20]);
          legal         = 1'b1;
        end else if ((funct3 == F3_SRA) && (funct7 == F7_ALT)) begin
          entry_c.ctrl  = ALU_SRAI;
          entry_c.data2 = ALU_DATA_W'(inst[24:20]);
          legal         = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
    illegal_c = ~legal;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes instructions and hands ALU control + operands downstream
// through a valid/ready handshake backed by a one-entry skid buffer.
// Optional build macro ALU_ISSUE_ILLEGAL_CNT_EN adds a saturating illegal-instruction counter.
module alu_issue_stage #(
  parameter int unsigned DATA_W = alu_pkg::ALU_DATA_W,
  parameter int unsigned RD_W   = alu_pkg::ALU_RD_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  alu_issue_stage_if.slave   bus
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [7:0]         illegal_cnt_o
`endif
);

  import alu_pkg::*;

  issue_entry_t dec_entry_c;
  logic         dec_illegal_c;

  issue_entry_t out_q;
  issue_entry_t skid_q;
  logic         out_valid_q;
  logic         skid_valid_q;
  logic         ready_q;

  logic         accept_c;
  logic         push_c;
  logic         advance_c;

  alu_issue_dec u_dec (
    .inst      (bus.inst_i),
    .rs1_data  (bus.rs1_data_i),
    .rs2_data  (bus.rs2_data_i),
    .entry_c   (dec_entry_c),
    .illegal_c (dec_illegal_c)
  );

  // Illegal encodings complete the handshake but never enter the pipeline.
  assign accept_c  = bus.valid_i && ready_q;
  assign push_c    = accept_c && !dec_illegal_c;
  assign advance_c = !out_valid_q || bus.ready_i;

  // Output register, skid buffer and registered ready; flush overrides every other event.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (flush_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (advance_c) begin
      if (skid_valid_q) begin
        // ready_q is low while the skid is full, so nothing new is accepted here.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else begin
        out_valid_q <= push_c;
        if (push_c) begin
          out_q <= dec_entry_c;
        end
      end
    end else if (push_c) begin
      skid_q       <= dec_entry_c;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end

  assign bus.ready_o   = ready_q;
  assign bus.valid_o   = out_valid_q;
  assign bus.ALUCtrl_o = out_q.ctrl;
  assign bus.data1_o   = DATA_W'(out_q.data1);
  assign bus.data2_o   = DATA_W'(out_q.data2);
  assign bus.rd_o      = RD_W'(out_q.rd);

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt_q;

  // Saturating count of accepted illegal instructions; counts even across a flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      illegal_cnt_q <= 8'd0;
    end else if (accept_c && dec_illegal_c && (illegal_cnt_q != 8'hFF)) begin
      illegal_cnt_q <= illegal_cnt_q + 8'd1;
    end
  end

  assign illegal_cnt_o = illegal_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors feed a scoreboard queue,
// a negedge monitor pops and compares every delivered entry.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  alu_issue_stage_if #(.DATA_W(32), .RD_W(5)) ifc ();

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [7:0] illegal_cnt;
`endif

  alu_issue_stage #(.DATA_W(32), .RD_W(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (ifc)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    .illegal_cnt_o (illegal_cnt)
`endif
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ill_n = 0;
  bit   busy  = 1'b0;
  exp_t sbq[$];

  exp_t mon_e;
  exp_t mon_cur;
  exp_t hold_e;
  bit   hold_v = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop/compare on every completed output handshake; check stability while stalled.
  always @(negedge clk) begin
    mon_cur = {ifc.ALUCtrl_o, ifc.data1_o, ifc.data2_o, ifc.rd_o};
    if (!rst && ifc.valid_o && ifc.ready_i) begin
      hold_v = 1'b0;
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got ctrl=%0d d1=%h d2=%h rd=%0d, expected no entry",
                 mon_cur.ctrl, mon_cur.d1, mon_cur.d2, mon_cur.rd);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_cur !== mon_e) begin
          n_bad++;
          $display("FAIL entry: got ctrl=%0d d1=%h d2=%h rd=%0d, expected ctrl=%0d d1=%h d2=%h rd=%0d",
                   mon_cur.ctrl, mon_cur.d1, mon_cur.d2, mon_cur.rd,
                   mon_e.ctrl, mon_e.d1, mon_e.d2, mon_e.rd);
        end
      end
    end else if (!rst && ifc.valid_o && !ifc.ready_i) begin
      if (hold_v) begin
        n_cmp++;
        if (mon_cur !== hold_e) begin
          n_bad++;
          $display("FAIL stall_stable: got %h, expected %h", mon_cur, hold_e);
        end
      end
      hold_e = mon_cur;
      hold_v = 1'b1;
    end else begin
      hold_v = 1'b0;
    end
  end

  // Present one instruction until accepted; push the hand-computed result if it is legal.
  task automatic issue(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2,
                       input bit legal, input logic [2:0] ctrl, input logic [31:0] d2,
                       input logic [4:0] rd);
    bit acc = 1'b0;
    int waitc = 0;
    busy = 1'b1;
    ifc.valid_i    = 1'b1;
    ifc.inst_i     = inst;
    ifc.rs1_data_i = r1;
    ifc.rs2_data_i = r2;
    while (!acc && waitc < 60) begin
      @(negedge clk);
      acc = ifc.ready_o;
      @(posedge clk);
      waitc++;
    end
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: got ready_o=0 for %0d cycles, expected acceptance", waitc);
    end else if (legal) begin
      sbq.push_back({ctrl, r1, d2, rd});
    end else begin
      ill_n++;
    end
    #1;
    ifc.valid_i = 1'b0;
    busy = 1'b0;
  endtask

  // Wait (bounded) until every expected entry has been delivered.
  task automatic drain();
    int c = 0;
    while ((sbq.size() != 0 || busy) && c < 100) begin
      @(posedge clk);
      c++;
    end
    check("drain_empty", 32'(sbq.size()), 0);
    #1;
  endtask

  task automatic check_cnt(input string name);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    check(name, 32'(illegal_cnt), (ill_n > 255) ? 255 : ill_n);
`else
    if (name.len() == 0) $display("empty name");
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    ifc.valid_i    = 1'b0;
    ifc.ready_i    = 1'b1;
    ifc.inst_i     = 32'h0;
    ifc.rs1_data_i = 32'h0;
    ifc.rs2_data_i = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_valid_o", 32'(ifc.valid_o), 0);
    check("reset_ctrl", 32'(ifc.ALUCtrl_o), 0);
    check("reset_data1", ifc.data1_o, 0);
    check("reset_data2", ifc.data2_o, 0);
    check("reset_rd", 32'(ifc.rd_o), 0);
    check("reset_ready_o", 32'(ifc.ready_o), 1);
    check_cnt("reset_illegal_cnt");
    @(posedge clk);
    #1;

    // add with one-cycle latency
    issue(32'h002081B3, 32'd5, 32'd7, 1'b1, 3'b011, 32'd7, 5'd3);
    @(negedge clk);
    check("add_latency_valid", 32'(ifc.valid_o), 1);
    @(posedge clk);
    #1;

    // back-to-back decode coverage
    issue(32'hFFF08293, 32'd10, 32'd99, 1'b1, 3'b110, 32'hFFFFFFFF, 5'd5);
    issue(32'h07B08293, 32'd1, 32'd99, 1'b1, 3'b110, 32'd123, 5'd5);
    issue(32'h4030D313, 32'h80000000, 32'd99, 1'b1, 3'b111, 32'd3, 5'd6);
    issue(32'h402081B3, 32'd20, 32'd8, 1'b1, 3'b100, 32'd8, 5'd3);
    issue(32'h022081B3, 32'd6, 32'd9, 1'b1, 3'b101, 32'd9, 5'd3);
    issue(32'h0020F1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b1, 3'b000, 32'h0FF00FF0, 5'd3);
    issue(32'h0020C1B3, 32'h12345678, 32'hFFFF0000, 1'b1, 3'b001, 32'hFFFF0000, 5'd3);
    issue(32'h002091B3, 32'd1, 32'd31, 1'b1, 3'b010, 32'd31, 5'd3);
    issue(32'h00208033, 32'd2, 32'd3, 1'b1, 3'b011, 32'd3, 5'd0);

    // illegal: slli is consumed but produces no entry
    issue(32'h00001013, 32'd1, 32'd2, 1'b0, 3'b000, 32'd0, 5'd0);
    check_cnt("illegal_cnt_first");
    @(negedge clk);
    check("illegal_no_valid", 32'(ifc.valid_o), 0);
    @(posedge clk);
    #1;
    issue(32'h402091B3, 32'd1, 32'd2, 1'b0, 3'b000, 32'd0, 5'd0);
    issue(32'h00000000, 32'd1, 32'd2, 1'b0, 3'b000, 32'd0, 5'd0);
    issue(32'h0000D013, 32'd1, 32'd2, 1'b0, 3'b000, 32'd0, 5'd0);
    issue(32'h0220C1B3, 32'd1, 32'd2, 1'b0, 3'b000, 32'd0, 5'd0);
    issue(32'h002081B3, 32'd40, 32'd2, 1'b1, 3'b011, 32'd2, 5'd3);
    drain();

    // backpressure: output + skid fill, third held upstream, then in-order release
    ifc.ready_i = 1'b0;
    issue(32'h002081B3, 32'd1, 32'd11, 1'b1, 3'b011, 32'd11, 5'd3);
    issue(32'h002081B3, 32'd2, 32'd22, 1'b1, 3'b011, 32'd22, 5'd3);
    @(negedge clk);
    check("bp_ready_low", 32'(ifc.ready_o), 0);
    check("bp_valid_high", 32'(ifc.valid_o), 1);
    check("bp_head_data1", ifc.data1_o, 1);
    fork
      issue(32'h002081B3, 32'd3, 32'd33, 1'b1, 3'b011, 32'd33, 5'd3);
    join_none
    repeat (3) @(negedge clk);
    check("bp_ready_still_low", 32'(ifc.ready_o), 0);
    check("bp_queue_depth", 32'(sbq.size()), 2);
    @(posedge clk);
    #1 ifc.ready_i = 1'b1;
    #1;
    drain();

    // flush with output and skid both full
    ifc.ready_i = 1'b0;
    issue(32'h002081B3, 32'd4, 32'd44, 1'b1, 3'b011, 32'd44, 5'd3);
    issue(32'h002081B3, 32'd5, 32'd55, 1'b1, 3'b011, 32'd55, 5'd3);
    @(negedge clk);
    check("flush_pre_ready", 32'(ifc.ready_o), 0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    sbq.delete();
    @(negedge clk);
    check("flush_valid_o", 32'(ifc.valid_o), 0);
    check("flush_ready_o", 32'(ifc.ready_o), 1);
    // flush wins over a same-cycle acceptance
    @(posedge clk);
    #1;
    ifc.inst_i     = 32'h002081B3;
    ifc.rs1_data_i = 32'd6;
    ifc.rs2_data_i = 32'd66;
    ifc.valid_i    = 1'b1;
    flush          = 1'b1;
    @(posedge clk);
    #1;
    ifc.valid_i = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check("flush_accept_drop", 32'(ifc.valid_o), 0);
    @(posedge clk);
    #1 ifc.ready_i = 1'b1;
    issue(32'h002081B3, 32'd7, 32'd77, 1'b1, 3'b011, 32'd77, 5'd3);
    drain();

    // illegal counter saturation boundaries
    while (ill_n < 300) begin
      issue(32'h00001013, 32'd0, 32'd0, 1'b0, 3'b000, 32'd0, 5'd0);
      if (ill_n == 254 || ill_n == 255 || ill_n == 256) check_cnt("illegal_cnt_edge");
    end
    check_cnt("illegal_cnt_sat");

    // asynchronous reset mid-stream
    ifc.ready_i = 1'b0;
    issue(32'h002081B3, 32'hDEADBEEF, 32'd88, 1'b1, 3'b011, 32'd88, 5'd3);
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid_o", 32'(ifc.valid_o), 0);
    check("rst_async_ctrl", 32'(ifc.ALUCtrl_o), 0);
    check("rst_async_data1", ifc.data1_o, 0);
    check("rst_async_data2", ifc.data2_o, 0);
    check("rst_async_rd", 32'(ifc.rd_o), 0);
    sbq.delete();
    ill_n = 0;
    check_cnt("rst_async_illegal_cnt");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready_o", 32'(ifc.ready_o), 1);
    @(posedge clk);
    #1 ifc.ready_i = 1'b1;
    issue(32'h402081B3, 32'd100, 32'd1, 1'b1, 3'b100, 32'd1, 5'd3);
    drain();

    repeat (2) @(posedge clk);
    check("final_queue_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
